// File: rtl/display_layer_arbiter_if.sv
// Pixel-domain bus between the VGA timing/layer sources and the display layer arbiter.
// The master side drives timing, layer hits/colours and config; the slave side drives the pins.
interface display_layer_arbiter_if #(
  parameter int COLOR_W = 12
);
  logic               in_valid;
  logic               in_hsync;
  logic               in_vsync;
  logic               mouse_hit;
  logic [COLOR_W-1:0] mouse_pix;
  logic               card_hit;
  logic [COLOR_W-1:0] card_pix;
  logic               button_hit;
  logic [COLOR_W-1:0] button_pix;
  logic [COLOR_W-1:0] bg_pix;
  logic [2:0]         cfg_layer_en;
  logic               hsync;
  logic               vsync;
  logic [3:0]         vgaRed;
  logic [3:0]         vgaGreen;
  logic [3:0]         vgaBlue;
  logic [1:0]         cur_layer;
  logic               frame_start;

  modport master (
    output in_valid, in_hsync, in_vsync,
    output mouse_hit, mouse_pix, card_hit, card_pix, button_hit, button_pix, bg_pix,
    output cfg_layer_en,
    input  hsync, vsync, vgaRed, vgaGreen, vgaBlue, cur_layer, frame_start
  );

  modport slave (
    input  in_valid, in_hsync, in_vsync,
    input  mouse_hit, mouse_pix, card_hit, card_pix, button_hit, button_pix, bg_pix,
    input  cfg_layer_en,
    output hsync, vsync, vgaRed, vgaGreen, vgaBlue, cur_layer, frame_start
  );
endinterface

// File: rtl/display_layer_arbiter.sv
// Two-stage per-pixel compositor: mouse > card/button (rotating tie) > background.
// Optional build macro CURSOR_BLINK_EN hides the cursor every other 32 frames.
module display_layer_arbiter #(
  parameter int               COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = '0,
  parameter bit               TIE_ROTATE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  display_layer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    LAYER_BG     = 2'd0,
    LAYER_BUTTON = 2'd1,
    LAYER_CARD   = 2'd2,
    LAYER_MOUSE  = 2'd3
  } layer_e;

  logic               vsync_prev;
  logic               frame_edge;
  logic [2:0]         shadow_en;
  logic               tie_ptr;
  logic               frame_start_q;
  logic               mouse_ok;

  logic               s1_valid;
  logic               s1_hsync;
  logic               s1_vsync;
  logic               s1_mouse_hit;
  logic               s1_card_hit;
  logic               s1_button_hit;
  logic               s1_tie;
  logic [COLOR_W-1:0] s1_mouse_pix;
  logic [COLOR_W-1:0] s1_card_pix;
  logic [COLOR_W-1:0] s1_button_pix;
  logic [COLOR_W-1:0] s1_bg_pix;

  layer_e             sel_layer;
  logic [COLOR_W-1:0] sel_pix;

  layer_e             layer_q;
  logic [COLOR_W-1:0] pix_q;
  logic               hsync_q;
  logic               vsync_q;

  assign frame_edge = vsync_prev & ~bus.in_vsync;

  // Frame-boundary bookkeeping: enables and tie pointer only move on a vsync falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev    <= 1'b1;
      shadow_en     <= 3'b111;
      tie_ptr       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vsync_prev    <= bus.in_vsync;
      frame_start_q <= frame_edge;
      if (frame_edge) begin
        shadow_en <= bus.cfg_layer_en;
        tie_ptr   <= TIE_ROTATE ? ~tie_ptr : 1'b0;
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_edge) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign mouse_ok = shadow_en[2] & ~frame_cnt[5];
`else
  assign mouse_ok = shadow_en[2];
`endif

  // Stage 1 captures the pixel with the shadow enables and tie pointer that were current for it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_hsync      <= 1'b1;
      s1_vsync      <= 1'b1;
      s1_mouse_hit  <= 1'b0;
      s1_card_hit   <= 1'b0;
      s1_button_hit <= 1'b0;
      s1_tie        <= 1'b0;
      s1_mouse_pix  <= '0;
      s1_card_pix   <= '0;
      s1_button_pix <= '0;
      s1_bg_pix     <= '0;
    end else begin
      s1_valid      <= bus.in_valid;
      s1_hsync      <= bus.in_hsync;
      s1_vsync      <= bus.in_vsync;
      s1_mouse_hit  <= bus.mouse_hit & mouse_ok;
      s1_card_hit   <= bus.card_hit & shadow_en[1];
      s1_button_hit <= bus.button_hit & shadow_en[0];
      s1_tie        <= tie_ptr;
      s1_mouse_pix  <= bus.mouse_pix;
      s1_card_pix   <= bus.card_pix;
      s1_button_pix <= bus.button_pix;
      s1_bg_pix     <= bus.bg_pix;
    end
  end

  always_comb begin
    sel_layer = LAYER_BG;
    sel_pix   = s1_bg_pix;
    if (!s1_valid) begin
      sel_layer = LAYER_BG;
      sel_pix   = BLANK_COLOR;
    end else if (s1_mouse_hit) begin
      sel_layer = LAYER_MOUSE;
      sel_pix   = s1_mouse_pix;
    end else if (s1_card_hit && s1_button_hit) begin
      if (s1_tie) begin
        sel_layer = LAYER_BUTTON;
        sel_pix   = s1_button_pix;
      end else begin
        sel_layer = LAYER_CARD;
        sel_pix   = s1_card_pix;
      end
    end else if (s1_card_hit) begin
      sel_layer = LAYER_CARD;
      sel_pix   = s1_card_pix;
    end else if (s1_button_hit) begin
      sel_layer = LAYER_BUTTON;
      sel_pix   = s1_button_pix;
    end
  end

  // Stage 2 keeps the syncs in step with the selected colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q <= LAYER_BG;
      pix_q   <= BLANK_COLOR;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      layer_q <= sel_layer;
      pix_q   <= sel_pix;
      hsync_q <= s1_hsync;
      vsync_q <= s1_vsync;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vgaRed      = pix_q[11:8];
  assign bus.vgaGreen    = pix_q[7:4];
  assign bus.vgaBlue     = pix_q[3:0];
  assign bus.cur_layer   = layer_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_layer_arbiter.sv
// Self-checking bench for display_layer_arbiter: frame-level reference model, directed and random stimulus.
// A second instance with TIE_ROTATE=0 shares the same inputs.
module tb_display_layer_arbiter;

  localparam int COLOR_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_layer_arbiter_if #(.COLOR_W(COLOR_W)) bus ();
  display_layer_arbiter_if #(.COLOR_W(COLOR_W)) bus0 ();

  assign bus0.in_valid     = bus.in_valid;
  assign bus0.in_hsync     = bus.in_hsync;
  assign bus0.in_vsync     = bus.in_vsync;
  assign bus0.mouse_hit    = bus.mouse_hit;
  assign bus0.mouse_pix    = bus.mouse_pix;
  assign bus0.card_hit     = bus.card_hit;
  assign bus0.card_pix     = bus.card_pix;
  assign bus0.button_hit   = bus.button_hit;
  assign bus0.button_pix   = bus.button_pix;
  assign bus0.bg_pix       = bus.bg_pix;
  assign bus0.cfg_layer_en = bus.cfg_layer_en;

  display_layer_arbiter #(.COLOR_W(COLOR_W), .BLANK_COLOR(12'h000), .TIE_ROTATE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  display_layer_arbiter #(.COLOR_W(COLOR_W), .BLANK_COLOR(12'h000), .TIE_ROTATE(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic        hsync;
    logic        vsync;
    logic [11:0] color;
    logic [1:0]  layer;
    logic [11:0] color0;
    logic [1:0]  layer0;
  } exp_t;

  // Model state: what the pins show now, what they show next cycle, and per-frame settings
  exp_t       exp_out;
  exp_t       exp_next;
  logic       exp_fs;
  logic [2:0] m_en;
  int         m_frames;
  logic       m_vsync_last;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  function automatic bit cursor_visible(input int frames);
`ifdef CURSOR_BLINK_EN
    return (frames % 64) < 32;
`else
    return (frames >= 0);
`endif
  endfunction

  // Winner from the layer rules, returned as {layer, colour}
  function automatic logic [13:0] pick(input bit button_wins_tie);
    bit c, b;
    if (!bus.in_valid) return {2'd0, 12'h000};
    if (bus.mouse_hit && m_en[2] && cursor_visible(m_frames)) return {2'd3, bus.mouse_pix};
    c = bus.card_hit && m_en[1];
    b = bus.button_hit && m_en[0];
    if (c && b) return button_wins_tie ? {2'd1, bus.button_pix} : {2'd2, bus.card_pix};
    if (c) return {2'd2, bus.card_pix};
    if (b) return {2'd1, bus.button_pix};
    return {2'd0, bus.bg_pix};
  endfunction

  task automatic model_reset();
    exp_out      = '{1'b1, 1'b1, 12'h000, 2'd0, 12'h000, 2'd0};
    exp_next     = exp_out;
    exp_fs       = 1'b0;
    m_en         = 3'b111;
    m_frames     = 0;
    m_vsync_last = 1'b1;
  endtask

  task automatic model_update();
    logic [13:0] r, r0;
    bit          fell;
    if (rst) begin
      model_reset();
      return;
    end
    exp_out = exp_next;
    r  = pick(m_frames % 2 == 1);
    r0 = pick(1'b0);
    exp_next = '{bus.in_hsync, bus.in_vsync, r[11:0], r[13:12], r0[11:0], r0[13:12]};
    fell   = m_vsync_last && !bus.in_vsync;
    exp_fs = fell;
    if (fell) begin
      m_en     = bus.cfg_layer_en;
      m_frames = m_frames + 1;
    end
    m_vsync_last = bus.in_vsync;
  endtask

  task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("hsync", {13'd0, bus.hsync}, {13'd0, exp_out.hsync});
    cmp("vsync", {13'd0, bus.vsync}, {13'd0, exp_out.vsync});
    cmp("color", {2'd0, bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, {2'd0, exp_out.color});
    cmp("cur_layer", {12'd0, bus.cur_layer}, {12'd0, exp_out.layer});
    cmp("frame_start", {13'd0, bus.frame_start}, {13'd0, exp_fs});
    cmp("color_norot", {2'd0, bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}, {2'd0, exp_out.color0});
    cmp("layer_norot", {12'd0, bus0.cur_layer}, {12'd0, exp_out.layer0});
  endtask

  // Hand-computed expectations checked against both the DUT and the model
  task automatic checkLiteral(input string name, input logic [11:0] color, input logic [1:0] layer,
                              input logic [11:0] color0, input logic [1:0] layer0);
    cmp({name, "_dut"}, {bus.cur_layer, bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, {layer, color});
    cmp({name, "_dut0"}, {bus0.cur_layer, bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}, {layer0, color0});
    cmp({name, "_model"}, {exp_out.layer, exp_out.color}, {layer, color});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic applyStimulus(input logic valid, input logic mh, input logic ch, input logic bh,
                               input logic [11:0] mp, input logic [11:0] cp,
                               input logic [11:0] bp, input logic [11:0] gp);
    bus.in_valid   = valid;
    bus.mouse_hit  = mh;
    bus.card_hit   = ch;
    bus.button_hit = bh;
    bus.mouse_pix  = mp;
    bus.card_pix   = cp;
    bus.button_pix = bp;
    bus.bg_pix     = gp;
  endtask

  task automatic vsyncPulse();
    bus.in_vsync = 1'b0;
    cycle();
    bus.in_vsync = 1'b1;
    cycle();
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  initial begin
    rst               = 1'b1;
    bus.in_vsync      = 1'b0;
    bus.in_hsync      = 1'b1;
    bus.cfg_layer_en  = 3'b111;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h123, 12'h456, 12'h789, 12'h321);
    model_reset();
    check_en = 1'b1;

    // Reset holds the pins idle even with live video at the inputs
    cycles(3);
    checkLiteral("reset_hold", 12'h000, 2'd0, 12'h000, 2'd0);
    cmp("reset_syncs", {12'd0, bus.hsync, bus.vsync}, 14'd3);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
    bus.in_vsync = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    checkLiteral("release_lat1", 12'h000, 2'd0, 12'h000, 2'd0);
    cycle();
    checkLiteral("release_lat2", 12'hABC, 2'd3, 12'hABC, 2'd3);

    // Priority
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'hF00, 12'h0F0, 12'h00F, 12'h555);
    cycles(2);
    checkLiteral("prio_mouse", 12'hF00, 2'd3, 12'hF00, 2'd3);
    bus.mouse_hit = 1'b0;
    cycles(2);
    checkLiteral("prio_card", 12'h0F0, 2'd2, 12'h0F0, 2'd2);

    // Tie rotation over three frames
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'hF00, 12'h111, 12'h222, 12'h555);
    cycles(2);
    checkLiteral("tie_f0", 12'h111, 2'd2, 12'h111, 2'd2);
    vsyncPulse();
    cycles(2);
    checkLiteral("tie_f1", 12'h222, 2'd1, 12'h111, 2'd2);
    vsyncPulse();
    cycles(2);
    checkLiteral("tie_f2", 12'h111, 2'd2, 12'h111, 2'd2);

    // Mid-frame enable change waits for the next vsync edge
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'hF00, 12'h0F0, 12'h00F, 12'h555);
    cycles(2);
    bus.cfg_layer_en = 3'b011;
    cycles(3);
    checkLiteral("shadow_hold", 12'hF00, 2'd3, 12'hF00, 2'd3);
    bus.in_vsync = 1'b0;
    cycle();
    cmp("fs_pulse", {13'd0, bus.frame_start}, 14'd1);
    cycle();
    cmp("fs_single", {13'd0, bus.frame_start}, 14'd0);
    checkLiteral("shadow_edge_px", 12'hF00, 2'd3, 12'hF00, 2'd3);
    cycle();
    checkLiteral("shadow_after", 12'h0F0, 2'd2, 12'h0F0, 2'd2);
    cycles(4);
    bus.in_vsync     = 1'b1;
    bus.cfg_layer_en = 3'b111;
    cycles(2);

    // Blanking ignores hits; hsync lags by exactly two cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'hF00, 12'h0F0, 12'h00F, 12'h555);
    cycles(2);
    checkLiteral("blank", 12'h000, 2'd0, 12'h000, 2'd0);
    bus.in_hsync = 1'b0;
    cycle();
    cmp("hsync_lag1", {13'd0, bus.hsync}, 14'd1);
    cycle();
    cmp("hsync_lag2", {13'd0, bus.hsync}, 14'd0);
    bus.in_hsync = 1'b1;
    cycles(2);

    // Reset mid-frame blanks at once
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'hF00, 12'h0F0, 12'h00F, 12'h555);
    cycles(3);
    rst = 1'b1;
    model_reset();
    #1;
    checkLiteral("midframe_rst", 12'h000, 2'd0, 12'h000, 2'd0);
    cycle();
    rst = 1'b0;
    cycles(3);

    // Cursor visibility across 65 frames
    resetPulse();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'hF00, 12'h0F0, 12'h00F, 12'h555);
    cycles(2);
    for (int k = 0; k <= 64; k++) begin
      if (cursor_visible(k)) checkLiteral("blink_vis", 12'hF00, 2'd3, 12'hF00, 2'd3);
      else                   checkLiteral("blink_hid", 12'h0F0, 2'd2, 12'h0F0, 2'd2);
      vsyncPulse();
      cycles(2);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid   = ($urandom_range(0, 7) != 0);
      bus.in_hsync   = ($urandom_range(0, 9) != 0);
      bus.in_vsync   = ($urandom_range(0, 14) != 0);
      bus.mouse_hit  = $urandom_range(0, 1);
      bus.card_hit   = $urandom_range(0, 1);
      bus.button_hit = $urandom_range(0, 1);
      bus.mouse_pix  = 12'($urandom);
      bus.card_pix   = 12'($urandom);
      bus.button_pix = 12'($urandom);
      bus.bg_pix     = 12'($urandom);
      if ($urandom_range(0, 49) == 0) bus.cfg_layer_en = 3'($urandom);
      if (i == 1500) resetPulse();
      else cycle();
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_layer_arbiter.md
Name: display_layer_arbiter

Overview:
- Per-pixel compositor and arbiter between the VGA timing generator and the vgaRed/Green/Blue/hsync/vsync pins.
- Four pixel sources compete for each pixel: mouse cursor, card, button and background. Fixed priority is mouse > card = button > background.
- Card/button ties are resolved by a per-frame rotating pointer.
- Layer enables are shadow-registered at frame start so configuration changes never tear mid-frame. Sync outputs are delayed to stay aligned with the 2-stage colour pipeline.

Parameters:
- COLOR_W, 12: pixel width, 4 bits each R/G/B, packed {R,G,B}.
- BLANK_COLOR, 12'h000: colour driven when the pixel is not in the active area.
- TIE_ROTATE, 1: 1 = card/button tie winner alternates each frame; 0 = card always wins the tie.

Ports:
- clk  in  1  pixel-domain clock (one pixel per cycle)
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  active-video flag from vga_controller
- in_hsync  in  1  active-low hsync from vga_controller
- in_vsync  in  1  active-low vsync from vga_controller
- mouse_hit  in  1  mouse layer covers this pixel
- mouse_pix  in  COLOR_W  mouse colour
- card_hit  in  1  card layer covers this pixel
- card_pix  in  COLOR_W  card colour
- button_hit  in  1  button layer covers this pixel
- button_pix  in  COLOR_W  button colour
- bg_pix  in  COLOR_W  background colour
- cfg_layer_en  in  3  {mouse,card,button} enables; sampled only at frame start
- hsync  out  1  in_hsync delayed 2 cycles
- vsync  out  1  in_vsync delayed 2 cycles
- vgaRed  out  4  pix_out[11:8]
- vgaGreen  out  4  pix_out[7:4]
- vgaBlue  out  4  pix_out[3:0]
- cur_layer  out  2  winning layer: 0 bg, 1 button, 2 card, 3 mouse; aligned with colour
- frame_start  out  1  one-cycle pulse on detected vsync falling edge (stage-1 timing)

Behaviour:

Reset (asynchronous, immediate):
- hsync = 1, vsync = 1, colour = BLANK_COLOR, cur_layer = 0, frame_start = 0.
- Shadow enables = 3'b111, tie pointer = 0 (card first), vsync_prev = 1, all pipeline valids = 0.

Stage 1 (register inputs):
- Registers all hit/pix inputs, in_valid, in_hsync and in_vsync.
- Hit flags are masked by the shadow enables as they are registered.

Stage 2 (select):
- Priority is mouse > (card vs button) > bg.
- Only card hit: card wins. Only button hit: button wins.
- Both card and button hit: winner is card when tie pointer = 0, button when it is 1.
- Result is registered into the colour outputs and cur_layer.
- If the stage-2 valid is 0: colour = BLANK_COLOR and cur_layer = 0, regardless of hits.

Latency:
- Exactly 2 cycles from inputs to colour, cur_layer, hsync and vsync. All four remain mutually aligned.

Frame start:
- Condition: vsync_prev == 1 and in_vsync == 0, evaluated on raw inputs.
- On that clock edge:
  - shadow enables <= cfg_layer_en;
  - tie pointer toggles if TIE_ROTATE = 1, otherwise holds 0;
  - frame_start pulses high for one cycle.
- The pixel sampled in the edge cycle uses the old shadow and pointer. The following pixel uses the new values.

Boundaries and corner cases:
- cfg_layer_en changing mid-frame has no effect until the next vsync falling edge.
- A disabled layer never wins, even if its hit is asserted. All layers disabled gives bg.
- Hits asserted while in_valid = 0 are ignored (blank output).
- vsync held low across many cycles produces a single frame_start pulse.
- Reset asserted mid-frame blanks immediately. After release, the first frame_start requires a genuine 1→0 vsync edge.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A 6-bit frame counter resets to 0 and increments on every frame_start, wrapping 63→0.
  - The mouse layer is treated as disabled while counter[5] = 1, i.e. the cursor is visible 32 frames and hidden 32 frames.
  - The mask is applied in stage 1 together with the shadow enable.
- Undefined: no counter logic exists; mouse eligibility depends only on the shadow enable.

Test Plan:
- Reset:
  - Stimulus: hold rst with in_vsync = 0, in_valid = 1.
  - Required: hsync = vsync = 1, colour = 0, cur_layer = 0. After release with all hits and bg_pix = 12'hABC, the colour reads 12'hABC exactly 2 cycles later.
- Priority:
  - Stimulus: mouse_hit = card_hit = 1, mouse_pix = 12'hF00, card_pix = 12'h0F0.
  - Required: 12'hF00 and cur_layer = 3. Dropping mouse_hit gives 12'h0F0 and cur_layer = 2 two cycles later.
- Tie rotation:
  - Stimulus: card_hit = button_hit = 1, card_pix = 12'h111, button_pix = 12'h222, across three vsync falling edges, TIE_ROTATE = 1.
  - Required: outputs 12'h111, 12'h222, 12'h111 in frames 0, 1, 2. With TIE_ROTATE = 0, always 12'h111.
- Shadow timing:
  - Stimulus: drive cfg_layer_en = 3'b011 mid-frame while mouse_hit = 1.
  - Required: mouse remains visible until the next vsync edge. The pixel after the edge shows card or bg.
- Blanking and sync alignment:
  - Stimulus: in_valid = 0 with all hits = 1; toggle in_hsync on a known cycle.
  - Required: colour = 0, cur_layer = 0; hsync toggles exactly 2 cycles later; frame_start pulses once per edge.
- CURSOR_BLINK_EN:
  - Stimulus: mouse_hit = 1 with 64 frame_start events.
  - Required: mouse wins in frames 0–31 and loses in frames 32–63. Wrap back to visible at frame 64.
